// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multicycle_controller_pkg;

    // Sequencer states; numeric values are visible to debug tooling, keep stable.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp from the sequencer to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/ALU_Decoder.sv
// ALU decoder: maps ALUOp plus funct fields to an ALUControl code.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: opb5 (op[5], 1 = R-type), funct3, funct7b5, ALUOp in; ALUControl out.
module ALU_Decoder
    import multicycle_controller_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            default: begin
                case (funct3)
                    // funct7b5 only selects sub for register-register ops;
                    // on addi that bit is part of the immediate.
                    3'b000:  ALUControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multi-cycle RISC-V datapath (shared memory, shared ALU).
// Latency: lw 5, sw 4, R/I 4, jal 4, branch 3 cycles with no memory stalls.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low.
// Ports: clk, rst_n; instruction fields op/funct3/funct7b5; zero flag; mem_ready;
//        datapath enables/selects out, plus instr_retired and illegal_instr pulses.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit BNE_EN  = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       instr_retired,
    output logic       illegal_instr
);

    logic [STATE_W-1:0] state_q, state_d;

    logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c;
    logic       reg_write_c, retired_c, illegal_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c, imm_src_c;
    logic [2:0] alu_ctrl_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        retired_c    = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; both the
                // IR and PC only commit once memory delivers.
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut from OldPC + imm.
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BRANCH:    state_d = S_BEQ;
                    default: begin
                        illegal_c = 1'b1;
                        retired_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                retired_c    = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole wait so memory sees a stable request.
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retired_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_JAL: begin
                // PC takes the target already in ALUOut; ALU forms OldPC+4 for rd.
                alu_src_a_c  = SRCA_OLDPC;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALUOUT;
                pc_write_c   = 1'b1;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_c = RES_ALUOUT;
                reg_write_c  = 1'b1;
                retired_c    = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c  = SRCA_RS1;
                alu_src_b_c  = SRCB_RS2;
                alu_op_c     = ALUOP_SUB;
                result_src_c = RES_ALUOUT;
                // funct3[0] distinguishes bne from beq when enabled.
                pc_write_c   = zero ^ (funct3[0] & BNE_EN);
                retired_c    = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format depends only on the opcode, not on the state.
    always_comb begin
        imm_src_c = IMM_I;
        case (op)
            OP_SW:     imm_src_c = IMM_S;
            OP_BRANCH: imm_src_c = IMM_B;
            OP_JAL:    imm_src_c = IMM_J;
            default:   imm_src_c = IMM_I;
        endcase
    end

    ALU_Decoder u_alu_dec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (alu_op_c),
        .ALUControl (alu_ctrl_c)
    );

    // Gate everything with rst_n so no enable or select leaks out during reset,
    // including the mem_ready-driven FETCH enables.
    assign pc_write      = rst_n & pc_write_c;
    assign adr_src       = rst_n & adr_src_c;
    assign mem_write     = rst_n & mem_write_c;
    assign ir_write      = rst_n & ir_write_c;
    assign reg_write     = rst_n & reg_write_c;
    assign instr_retired = rst_n & retired_c;
    assign illegal_instr = rst_n & illegal_c;
    assign result_src    = rst_n ? result_src_c : 2'b00;
    assign alu_src_a     = rst_n ? alu_src_a_c  : 2'b00;
    assign alu_src_b     = rst_n ? alu_src_b_c  : 2'b00;
    assign imm_src       = rst_n ? imm_src_c    : 2'b00;
    assign alu_control   = rst_n ? alu_ctrl_c   : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retired, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    logic       b0_pc_write, b0_adr_src, b0_mem_write, b0_ir_write, b0_reg_write;
    logic       b0_retired, b0_illegal;
    logic [1:0] b0_result_src, b0_alu_src_a, b0_alu_src_b, b0_imm_src;
    logic [2:0] b0_alu_control;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller #(.BNE_EN(1'b1), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .reg_write(reg_write),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr)
    );

    multicycle_controller #(.BNE_EN(1'b0), .STATE_W(4)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(b0_pc_write), .adr_src(b0_adr_src), .mem_write(b0_mem_write),
        .ir_write(b0_ir_write), .result_src(b0_result_src), .alu_src_a(b0_alu_src_a),
        .alu_src_b(b0_alu_src_b), .imm_src(b0_imm_src), .alu_control(b0_alu_control),
        .reg_write(b0_reg_write), .instr_retired(b0_retired), .illegal_instr(b0_illegal)
    );

    // Every test starts just after a rising edge with the DUT in FETCH;
    // outputs are sampled on the falling edge.
    task automatic test_reset;
        rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
        n_cmp++; if (ir_write !== 1'b0) begin n_bad++; $display("FAIL rst_ir_write: got %b want 0", ir_write); end
        n_cmp++; if (pc_write !== 1'b0) begin n_bad++; $display("FAIL rst_pc_write: got %b want 0", pc_write); end
        n_cmp++; if (alu_src_b !== 2'b00) begin n_bad++; $display("FAIL rst_alu_src_b: got %b want 00", alu_src_b); end
        n_cmp++; if (result_src !== 2'b00) begin n_bad++; $display("FAIL rst_result_src: got %b want 00", result_src); end
        n_cmp++; if (imm_src !== 2'b00) begin n_bad++; $display("FAIL rst_imm_src: got %b want 00", imm_src); end
        n_cmp++; if (b0_ir_write !== 1'b0) begin n_bad++; $display("FAIL rst_b0_ir_write: got %b want 0", b0_ir_write); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (ir_write !== 1'b0) begin n_bad++; $display("FAIL fetch_wait_ir_write: got %b want 0", ir_write); end
        n_cmp++; if (imm_src !== 2'b01) begin n_bad++; $display("FAIL sw_imm_src: got %b want 01", imm_src); end
        @(posedge clk); #1;
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL fetch_hold_state: got %0d want 0", dut.state_q); end
        mem_ready = 1'b1;
    endtask

    task automatic test_lw;
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        int rw_cnt = 0;
        int ret_cnt = 0;
        op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (dut.state_q !== exp_st[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, dut.state_q, exp_st[i]); end
            if (reg_write) rw_cnt++;
            if (instr_retired) ret_cnt++;
            if (i == 0) begin
                n_cmp++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin n_bad++; $display("FAIL lw_fetch_en: got ir=%b pc=%b want 1 1", ir_write, pc_write); end
                n_cmp++; if (alu_src_b !== 2'b10 || result_src !== 2'b10 || adr_src !== 1'b0) begin n_bad++; $display("FAIL lw_fetch_sel: got b=%b res=%b adr=%b want 10 10 0", alu_src_b, result_src, adr_src); end
                n_cmp++; if (alu_control !== 3'b000) begin n_bad++; $display("FAIL lw_fetch_alu: got %b want 000", alu_control); end
            end
            if (i == 1) begin
                n_cmp++; if (alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || imm_src !== 2'b00) begin n_bad++; $display("FAIL lw_decode_sel: got a=%b b=%b imm=%b want 01 01 00", alu_src_a, alu_src_b, imm_src); end
            end
            if (i == 2) begin
                n_cmp++; if (alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin n_bad++; $display("FAIL lw_memadr_sel: got a=%b b=%b want 10 01", alu_src_a, alu_src_b); end
            end
            if (i == 3) begin
                n_cmp++; if (adr_src !== 1'b1 || reg_write !== 1'b0) begin n_bad++; $display("FAIL lw_memread: got adr=%b rw=%b want 1 0", adr_src, reg_write); end
            end
            if (i == 4) begin
                n_cmp++; if (reg_write !== 1'b1 || result_src !== 2'b01 || instr_retired !== 1'b1) begin n_bad++; $display("FAIL lw_memwb: got rw=%b res=%b ret=%b want 1 01 1", reg_write, result_src, instr_retired); end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL lw_end_state: got %0d want 0", dut.state_q); end
        n_cmp++; if (rw_cnt != 1 || ret_cnt != 1) begin n_bad++; $display("FAIL lw_pulse_counts: got rw=%0d ret=%0d want 1 1", rw_cnt, ret_cnt); end
    endtask

    task automatic test_sw_wait;
        logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic       rdy    [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_rt [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int mw_cnt = 0;
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            n_cmp++; if (dut.state_q !== exp_st[i]) begin n_bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, dut.state_q, exp_st[i]); end
            n_cmp++; if (instr_retired !== exp_rt[i]) begin n_bad++; $display("FAIL sw_retired[%0d]: got %b want %b", i, instr_retired, exp_rt[i]); end
            if (mem_write) mw_cnt++;
            if (i == 3) begin
                n_cmp++; if (adr_src !== 1'b1 || mem_write !== 1'b1) begin n_bad++; $display("FAIL sw_memwrite_en: got adr=%b mw=%b want 1 1", adr_src, mem_write); end
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL sw_end_state: got %0d want 0", dut.state_q); end
        n_cmp++; if (mw_cnt != 4) begin n_bad++; $display("FAIL sw_mem_write_cycles: got %0d want 4", mw_cnt); end
    endtask

    task automatic test_alu_ops;
        logic [6:0] op_v  [6] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0010011};
        logic [2:0] f3_v  [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
        logic       f7_v  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] ctl_v [6] = '{3'b001, 3'b000, 3'b000, 3'b101, 3'b011, 3'b010};
        logic [3:0] st_v  [6] = '{4'd6, 4'd6, 4'd7, 4'd7, 4'd6, 4'd7};
        logic [1:0] b_v   [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        for (int v = 0; v < 6; v++) begin
            op = op_v[v]; funct3 = f3_v[v]; funct7b5 = f7_v[v]; mem_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    n_cmp++; if (alu_control !== 3'b000) begin n_bad++; $display("FAIL alu%0d_fetch_add: got %b want 000", v, alu_control); end
                end
                if (c == 2) begin
                    n_cmp++; if (dut.state_q !== st_v[v]) begin n_bad++; $display("FAIL alu%0d_exec_state: got %0d want %0d", v, dut.state_q, st_v[v]); end
                    n_cmp++; if (alu_control !== ctl_v[v]) begin n_bad++; $display("FAIL alu%0d_control: got %b want %b", v, alu_control, ctl_v[v]); end
                    n_cmp++; if (alu_src_a !== 2'b10 || alu_src_b !== b_v[v]) begin n_bad++; $display("FAIL alu%0d_srcs: got a=%b b=%b want 10 %b", v, alu_src_a, alu_src_b, b_v[v]); end
                end
                if (c == 3) begin
                    n_cmp++; if (dut.state_q !== 4'd9 || reg_write !== 1'b1 || result_src !== 2'b00 || instr_retired !== 1'b1) begin n_bad++; $display("FAIL alu%0d_wb: got st=%0d rw=%b res=%b ret=%b want 9 1 00 1", v, dut.state_q, reg_write, result_src, instr_retired); end
                end
                @(posedge clk); #1;
            end
            n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL alu%0d_end_state: got %0d want 0", v, dut.state_q); end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_branch;
        logic [2:0] f3_v  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       z_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       pw_v  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pw0_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        op = 7'b1100011;
        for (int v = 0; v < 4; v++) begin
            funct3 = f3_v[v]; zero = z_v[v]; mem_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    n_cmp++; if (imm_src !== 2'b10) begin n_bad++; $display("FAIL br%0d_imm_src: got %b want 10", v, imm_src); end
                end
                if (c == 2) begin
                    n_cmp++; if (dut.state_q !== 4'd10) begin n_bad++; $display("FAIL br%0d_state: got %0d want 10", v, dut.state_q); end
                    n_cmp++; if (pc_write !== pw_v[v]) begin n_bad++; $display("FAIL br%0d_pc_write: got %b want %b", v, pc_write, pw_v[v]); end
                    n_cmp++; if (b0_pc_write !== pw0_v[v]) begin n_bad++; $display("FAIL br%0d_pc_write_bne_off: got %b want %b", v, b0_pc_write, pw0_v[v]); end
                    n_cmp++; if (alu_control !== 3'b001 || instr_retired !== 1'b1 || reg_write !== 1'b0) begin n_bad++; $display("FAIL br%0d_ctl: got alu=%b ret=%b rw=%b want 001 1 0", v, alu_control, instr_retired, reg_write); end
                end
                @(posedge clk); #1;
            end
            n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL br%0d_end_state: got %0d want 0", v, dut.state_q); end
        end
        zero = 1'b0; funct3 = 3'b000;
    endtask

    task automatic test_jal_illegal;
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd8, 4'd9};
        logic [6:0] bad_op [2] = '{7'b1111111, 7'b0000000};
        op = 7'b1101111; mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (dut.state_q !== exp_st[c]) begin n_bad++; $display("FAIL jal_state[%0d]: got %0d want %0d", c, dut.state_q, exp_st[c]); end
            if (c == 1) begin
                n_cmp++; if (imm_src !== 2'b11) begin n_bad++; $display("FAIL jal_imm_src: got %b want 11", imm_src); end
            end
            if (c == 2) begin
                n_cmp++; if (pc_write !== 1'b1 || reg_write !== 1'b0 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin n_bad++; $display("FAIL jal_jump: got pc=%b rw=%b a=%b b=%b want 1 0 01 10", pc_write, reg_write, alu_src_a, alu_src_b); end
            end
            if (c == 3) begin
                n_cmp++; if (reg_write !== 1'b1 || pc_write !== 1'b0 || instr_retired !== 1'b1) begin n_bad++; $display("FAIL jal_wb: got rw=%b pc=%b ret=%b want 1 0 1", reg_write, pc_write, instr_retired); end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL jal_end_state: got %0d want 0", dut.state_q); end

        for (int v = 0; v < 2; v++) begin
            op = bad_op[v];
            @(negedge clk);
            n_cmp++; if (illegal_instr !== 1'b0) begin n_bad++; $display("FAIL ill%0d_fetch_flag: got %b want 0", v, illegal_instr); end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (dut.state_q !== 4'd1 || illegal_instr !== 1'b1 || instr_retired !== 1'b1) begin n_bad++; $display("FAIL ill%0d_decode: got st=%0d ill=%b ret=%b want 1 1 1", v, dut.state_q, illegal_instr, instr_retired); end
            n_cmp++; if (reg_write !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL ill%0d_no_write: got rw=%b mw=%b want 0 0", v, reg_write, mem_write); end
            @(posedge clk); #1;
            n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL ill%0d_next_state: got %0d want 0", v, dut.state_q); end
        end
    endtask

    task automatic test_reset_mid_store;
        op = 7'b0100011; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (dut.state_q !== 4'd5 || mem_write !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got st=%0d mw=%b want 5 1", dut.state_q, mem_write); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rmid_mem_write_async: got %b want 0", mem_write); end
        n_cmp++; if (dut.state_q !== 4'd0) begin n_bad++; $display("FAIL rmid_state_async: got %0d want 0", dut.state_q); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin n_bad++; $display("FAIL rmid_fetch_wait: got ir=%b pc=%b want 0 0", ir_write, pc_write); end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin n_bad++; $display("FAIL rmid_fetch_ready: got ir=%b pc=%b want 1 1", ir_write, pc_write); end
        @(posedge clk); #1;
        n_cmp++; if (dut.state_q !== 4'd1) begin n_bad++; $display("FAIL rmid_decode: got %0d want 1", dut.state_q); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_ops();
        test_branch();
        test_jal_illegal();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style sequencer that drives the multi-cycle RISC-V datapath: one shared memory for instructions and data, one ALU reused for PC+4, branch target and execute.
- Decodes the latched instruction fields.
- Steps through FETCH/DECODE/execute/writeback states and emits per-cycle mux selects and write enables.
- Supports a memory wait handshake. Replaces the single-cycle control path when the core is built in multi-cycle mode.

Parameters:
- BNE_EN, 1, 1 = funct3[0] inverts the branch condition (beq/bne); 0 = beq only.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- funct7b5  in  1  instruction register [30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  0 = PC drives memory address, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- imm_src  out  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register file write enable
- instr_retired  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset: state <= FETCH asynchronously. While rst_n = 0, every output is forced to 0.
- Outputs decode combinationally from state. Exceptions: pc_write additionally depends on zero/funct3; FETCH enables depend on mem_ready.
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, jal 1101111, branch 1100011.
- ALU op per state: 00 add, 01 sub, 10 funct-decoded.
  - R-type: sub if funct3 = 000 and funct7b5 = 1.
  - I-ALU: add for funct3 = 000, regardless of funct7b5.
  - funct3 = 010 gives slt, 110 gives or, 111 gives and.
- States and outputs (unlisted outputs are 0):
  - FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu op add, result_src 10; ir_write = pc_write = mem_ready. Hold while mem_ready = 0; go to DECODE when mem_ready = 1.
  - DECODE: alu_src_a 01, alu_src_b 01, add (precomputes branch target into ALUOut).
    - lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; jal -> JAL; branch -> BEQ.
    - Any other opcode: illegal_instr = 1, instr_retired = 1, go to FETCH (acts as a NOP).
  - MEMADR: alu_src_a 10, alu_src_b 01, add. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: adr_src 1. Hold until mem_ready, then -> MEMWB.
  - MEMWB: result_src 01, reg_write 1, instr_retired 1 -> FETCH.
  - MEMWRITE: adr_src 1, mem_write 1 held for the whole wait. Hold until mem_ready, then instr_retired 1 -> FETCH.
  - EXECUTER: alu_src_a 10, alu_src_b 00, alu op 10 -> ALUWB.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, alu op 10 -> ALUWB.
  - JAL: alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1 -> ALUWB (writes PC+4 to rd).
  - ALUWB: result_src 00, reg_write 1, instr_retired 1 -> FETCH.
  - BEQ: alu_src_a 10, alu_src_b 00, sub, result_src 00. pc_write = zero XOR (funct3[0] AND BNE_EN). instr_retired 1 -> FETCH.
- Latency (cycles, with mem_ready = 1): lw 5, sw 4, R/I 4, jal 4, branch 3.
- Each memory wait adds one cycle per mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction: the instruction is abandoned with no partial write; restart at FETCH.
- Unreachable state encodings return to FETCH on the next clock.

Decomposition:
- Shared package holds:
  - state encodings FETCH = 0 … BEQ = 10;
  - opcode constants;
  - ALUControl codes, ResultSrc, ALUSrcA/B and ImmSrc select codes.
- Sub-module: reuse the existing ALU_Decoder (opb5, funct3, funct7b5, ALUOp -> ALUControl) unchanged.
- The FSM plus an imm_src decoder stay in this module.

Test Plan:
- Reset then release with op = 0000011 (lw), mem_ready = 1 -> states 0,1,2,3,4,0; reg_write only in cycle 5 with result_src 01; instr_retired pulses once.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held 4 cycles, state stays 5; retire on the 4th cycle; total 7 cycles.
- R-type sub (funct3 000, funct7b5 1) -> alu_control 001 in EXECUTER; addi with funct7b5 = 1 -> alu_control 000.
- Branch, funct3 000: zero = 1 gives pc_write = 1, zero = 0 gives 0. funct3 001 (bne): inverted. BNE_EN = 0 with bne and zero = 1 gives pc_write = 1.
- jal -> pc_write in JAL, reg_write in ALUWB, 4 cycles; op = 1111111 -> illegal_instr pulse in DECODE, next state FETCH, no reg_write/mem_write.
- rst_n dropped during MEMWRITE with mem_write = 1 -> mem_write falls to 0 immediately (asynchronous); after release, FETCH with ir_write = mem_ready.
